// File: rtl/vector_fb_scheduler.sv
// Port-B scheduler for the vector framebuffer: arbitrates CPU accesses, phosphor-fade
// read-modify-write sweeps and line-draw pixel writes onto one registered memory port.
module vector_fb_scheduler #(
  parameter int FB_ADDR_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     vblank,
  input  logic                     fade_enable,
  input  logic [7:0]               fade_step,
  input  logic                     draw_req,
  input  logic [FB_ADDR_WIDTH-1:0] draw_addr,
  input  logic [7:0]               draw_data,
  output logic                     draw_ack,
  input  logic                     cpu_req,
  input  logic                     cpu_wr,
  input  logic [FB_ADDR_WIDTH-1:0] cpu_addr,
  input  logic [7:0]               cpu_wdata,
  output logic                     cpu_ack,
  output logic [7:0]               cpu_rdata,
  output logic [FB_ADDR_WIDTH-1:0] fb_addr,
  output logic                     fb_wr,
  output logic [7:0]               fb_wdata,
  input  logic [7:0]               fb_rdata,
  output logic                     sweep_active,
  output logic                     sweep_done,
  output logic                     overrun
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CPU_RD0 = 3'd1,
    CPU_RD1 = 3'd2,
    CPU_RD2 = 3'd3,
    SW_RD0  = 3'd4,
    SW_RD1  = 3'd5,
    SW_RD2  = 3'd6,
    SW_WR   = 3'd7
  } state_e;

  localparam logic [FB_ADDR_WIDTH-1:0] ADDR_ONE = {{(FB_ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_e                   state_q;
  logic                     vblank_last_q;
  logic                     sweep_pending_q;
  logic                     sweep_active_q;
  logic [7:0]               step_q;
  logic [FB_ADDR_WIDTH-1:0] sweep_cnt_q;
  logic [FB_ADDR_WIDTH-1:0] fb_addr_q;
  logic                     fb_wr_q;
  logic [7:0]               fb_wdata_q;
  logic                     draw_ack_q;
  logic                     cpu_ack_q;
  logic [7:0]               cpu_rdata_q;
  logic                     sweep_done_q;
  logic                     overrun_q;

  logic                     vblank_rise_s;
  logic                     last_pixel_s;
  logic                     arb_s;
  logic                     cpu_elig_s;
  logic                     sweep_elig_s;
  logic                     draw_elig_s;
  logic [FB_ADDR_WIDTH-1:0] sweep_addr_d;

  function automatic logic [7:0] sat_sub(input logic [7:0] d, input logic [7:0] s);
    if (d > s) begin
      return d - s;
    end else begin
      return 8'd0;
    end
  endfunction

  // Arbitration eligibility; the SW_WR exit of a non-final pixel arbitrates like IDLE
  always_comb begin
    vblank_rise_s = vblank & ~vblank_last_q;
    last_pixel_s  = &sweep_cnt_q;
    cpu_elig_s    = cpu_req & ~cpu_ack_q;
    sweep_elig_s  = sweep_pending_q | sweep_active_q;
    draw_elig_s   = draw_req & ~draw_ack_q & ~sweep_elig_s;
    arb_s         = (state_q == IDLE) | ((state_q == SW_WR) & ~last_pixel_s);
    if (state_q == SW_WR) begin
      sweep_addr_d = sweep_cnt_q + ADDR_ONE;
    end else if (sweep_active_q) begin
      sweep_addr_d = sweep_cnt_q;
    end else begin
      sweep_addr_d = '0;
    end
  end

  // Scheduler FSM with registered memory-port and handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      vblank_last_q   <= 1'b0;
      sweep_pending_q <= 1'b0;
      sweep_active_q  <= 1'b0;
      step_q          <= 8'd0;
      sweep_cnt_q     <= '0;
      fb_addr_q       <= '0;
      fb_wr_q         <= 1'b0;
      fb_wdata_q      <= 8'd0;
      draw_ack_q      <= 1'b0;
      cpu_ack_q       <= 1'b0;
      cpu_rdata_q     <= 8'd0;
      sweep_done_q    <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      vblank_last_q <= vblank;
      fb_wr_q       <= 1'b0;
      draw_ack_q    <= 1'b0;
      cpu_ack_q     <= 1'b0;
      sweep_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
      if (arb_s) begin
        sweep_cnt_q <= sweep_addr_d;
        if (cpu_elig_s) begin
          fb_addr_q <= cpu_addr;
          if (cpu_wr) begin
            fb_wr_q    <= 1'b1;
            fb_wdata_q <= cpu_wdata;
            cpu_ack_q  <= 1'b1;
            state_q    <= IDLE;
          end else begin
            state_q <= CPU_RD0;
          end
        end else if (sweep_elig_s) begin
          sweep_pending_q <= 1'b0;
          sweep_active_q  <= 1'b1;
          fb_addr_q       <= sweep_addr_d;
          state_q         <= SW_RD0;
        end else if (draw_elig_s) begin
          fb_addr_q  <= draw_addr;
          fb_wdata_q <= draw_data;
          fb_wr_q    <= 1'b1;
          draw_ack_q <= 1'b1;
          state_q    <= IDLE;
        end else begin
          state_q <= IDLE;
        end
      end else begin
        case (state_q)
          CPU_RD0: state_q <= CPU_RD1;
          CPU_RD1: state_q <= CPU_RD2;
          CPU_RD2: begin
            cpu_rdata_q <= fb_rdata;
            cpu_ack_q   <= 1'b1;
            state_q     <= IDLE;
          end
          SW_RD0: state_q <= SW_RD1;
          SW_RD1: state_q <= SW_RD2;
          SW_RD2: begin
            fb_wdata_q <= sat_sub(fb_rdata, step_q);
            fb_wr_q    <= 1'b1;
            state_q    <= SW_WR;
          end
          SW_WR: begin
            sweep_active_q <= 1'b0;
            sweep_done_q   <= 1'b1;
            state_q        <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
      // A rise during a sweep is only reported; it never queues a second sweep
      if (vblank_rise_s) begin
        if (sweep_active_q) begin
          overrun_q <= 1'b1;
        end else if (fade_enable && (fade_step != 8'd0) && !sweep_pending_q) begin
          sweep_pending_q <= 1'b1;
          step_q          <= fade_step;
        end
      end
    end
  end

  assign draw_ack     = draw_ack_q;
  assign cpu_ack      = cpu_ack_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign fb_addr      = fb_addr_q;
  assign fb_wr        = fb_wr_q;
  assign fb_wdata     = fb_wdata_q;
  assign sweep_active = sweep_active_q;
  assign sweep_done   = sweep_done_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_vector_fb_scheduler.sv
// Bench for vector_fb_scheduler: framebuffer model with 2-cycle read latency, vector table,
// fade sweeps checked against a whole-array decay model, and reset/overrun corner sequences.
module tb_vector_fb_scheduler;
  localparam int AW = 10;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          vblank;
  logic          fade_enable;
  logic [7:0]    fade_step;
  logic          draw_req;
  logic [AW-1:0] draw_addr;
  logic [7:0]    draw_data;
  logic          draw_ack;
  logic          cpu_req;
  logic          cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          cpu_ack;
  logic [7:0]    cpu_rdata;
  logic [AW-1:0] fb_addr;
  logic          fb_wr;
  logic [7:0]    fb_wdata;
  logic [7:0]    fb_rdata;
  logic          sweep_active;
  logic          sweep_done;
  logic          overrun;

  always #5 clk = ~clk;

  vector_fb_scheduler #(.FB_ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .vblank(vblank), .fade_enable(fade_enable), .fade_step(fade_step),
    .draw_req(draw_req), .draw_addr(draw_addr), .draw_data(draw_data), .draw_ack(draw_ack),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .fb_addr(fb_addr), .fb_wr(fb_wr),
    .fb_wdata(fb_wdata), .fb_rdata(fb_rdata), .sweep_active(sweep_active),
    .sweep_done(sweep_done), .overrun(overrun)
  );

  // Framebuffer: address register then output register, so data lands 2 cycles after fb_addr
  logic [7:0]    mem     [N];
  logic [7:0]    img     [N];
  logic [7:0]    exp_mem [N];
  logic          ld_all  = 1'b0;
  logic [AW-1:0] addr_r1 = '0;
  logic [7:0]    rdata_r = 8'd0;

  always @(posedge clk) begin
    if (ld_all) begin
      for (int i = 0; i < N; i++) mem[i] <= img[i];
    end else if (fb_wr) begin
      mem[fb_addr] <= fb_wdata;
    end
    addr_r1 <= fb_addr;
    rdata_r <= mem[addr_r1];
  end
  assign fb_rdata = rdata_r;

  typedef struct {
    bit            is_cpu;
    bit            wr;
    logic [AW-1:0] addr;
    logic [7:0]    data;
    int            lat;
    logic [7:0]    exp_rd;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] decay(input logic [7:0] d, input logic [7:0] s);
    int r;
    r = int'(d) - int'(s);
    if (r < 0) r = 0;
    return 8'(r);
  endfunction

  task automatic load_image();
    ld_all = 1'b1;
    tick();
    ld_all = 1'b0;
    for (int i = 0; i < N; i++) exp_mem[i] = img[i];
  endtask

  task automatic mem_compare(input string nm);
    int errs;
    errs = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== exp_mem[i]) errs++;
    check(nm, errs, 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int            lat;
    logic [AW-1:0] a;
    logic          w;
    logic [7:0]    wd;
    logic [7:0]    rd;
    lat = 0; a = '0; w = 1'b0; wd = 8'd0; rd = 8'd0;
    if (v.is_cpu) begin
      cpu_req = 1'b1; cpu_wr = v.wr; cpu_addr = v.addr; cpu_wdata = v.data;
    end else begin
      draw_req = 1'b1; draw_addr = v.addr; draw_data = v.data;
    end
    for (int i = 1; i <= 12; i++) begin
      tick();
      if ((v.is_cpu ? cpu_ack : draw_ack) === 1'b1) begin
        lat = i; a = fb_addr; w = fb_wr; wd = fb_wdata; rd = cpu_rdata;
        break;
      end
    end
    cpu_req  = 1'b0;
    draw_req = 1'b0;
    check($sformatf("vec%0d_latency", idx), lat, v.lat);
    check($sformatf("vec%0d_fb_addr", idx), a, v.addr);
    check($sformatf("vec%0d_fb_wr", idx), w, v.wr);
    if (v.wr) begin
      check($sformatf("vec%0d_fb_wdata", idx), wd, v.data);
      exp_mem[v.addr] = v.data;
    end else begin
      check($sformatf("vec%0d_cpu_rdata", idx), rd, v.exp_rd);
    end
    tick();
  endtask

  task automatic cpu_op(input bit wr, input logic [AW-1:0] a, input logic [7:0] d,
                        output int lat, output logic [7:0] rd);
    cpu_req = 1'b1; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
    lat = 0; rd = 8'd0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (cpu_ack === 1'b1) begin
        lat = i; rd = cpu_rdata;
        break;
      end
    end
    cpu_req = 1'b0;
    tick();
  endtask

  vec_t vecs [8];

  initial begin
    int         lat, dur, done_cnt, ov_cnt, draw_early, cpu_lat, cpu_t0, found;
    logic [7:0] step, rd, d;
    logic [AW-1:0] a;
    bit         wr;

    reset = 1'b1; vblank = 1'b0; fade_enable = 1'b0; fade_step = 8'd0;
    draw_req = 1'b0; draw_addr = '0; draw_data = 8'd0;
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = 8'd0;

    vecs[0] = '{1'b0, 1'b1, 10'h234, 8'hFF, 1, 8'h00};
    vecs[1] = '{1'b1, 1'b1, 10'h100, 8'h77, 1, 8'h00};
    vecs[2] = '{1'b1, 1'b0, 10'h042, 8'h00, 4, 8'h5A};
    vecs[3] = '{1'b1, 1'b0, 10'h100, 8'h00, 4, 8'h77};
    vecs[4] = '{1'b0, 1'b1, 10'h3FF, 8'h01, 1, 8'h00};
    vecs[5] = '{1'b1, 1'b0, 10'h3FF, 8'h00, 4, 8'h01};
    vecs[6] = '{1'b1, 1'b0, 10'h234, 8'h00, 4, 8'hFF};
    vecs[7] = '{1'b1, 1'b0, 10'h001, 8'h00, 4, 8'h00};

    for (int i = 0; i < N; i++) img[i] = 8'h00;
    img[10'h042] = 8'h5A;
    repeat (3) tick();
    check("rst_fb_wr", fb_wr, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_fb_wdata", fb_wdata, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_acks", {draw_ack, cpu_ack}, 0);
    check("rst_sweep_flags", {sweep_active, sweep_done, overrun}, 0);
    load_image();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Held draw request: grants every other cycle
    draw_req = 1'b1; draw_addr = 10'h010; draw_data = 8'h11;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("draw_rate%0d", i), draw_ack, (i % 2 == 0) ? 1 : 0);
    end
    draw_req = 1'b0;
    exp_mem[10'h010] = 8'h11;
    tick();
    mem_compare("table_mem");

    // Sweep A: known pixels plus random image, step 0x10
    for (int i = 0; i < N; i++) img[i] = 8'($urandom);
    img[0] = 8'h25; img[1] = 8'h08;
    load_image();
    fade_enable = 1'b1; fade_step = 8'h10; vblank = 1'b1;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (sweep_active === 1'b1) begin lat = i; break; end
    end
    check("sweep_start_latency", lat, 2);
    fade_enable = 1'b0; fade_step = 8'hFF; vblank = 1'b0;
    dur = 0; done_cnt = 0;
    for (int i = 1; i <= 4 * N + 60; i++) begin
      tick();
      if (sweep_done === 1'b1) begin
        done_cnt++;
        if (dur == 0) dur = i;
      end
      if (dur != 0 && i >= dur + 10) break;
    end
    check("sweep_duration", dur, 4 * N);
    check("sweep_done_count", done_cnt, 1);
    check("sweep_active_after", sweep_active, 0);
    for (int i = 0; i < N; i++) exp_mem[i] = decay(img[i], 8'h10);
    check("sweep_px0", mem[0], 8'h15);
    check("sweep_px1", mem[1], 8'h00);
    mem_compare("sweepA_mem");

    // Sweep B: random step, CPU and draw contention, second vblank rise
    for (int i = 0; i < N; i++) img[i] = 8'($urandom);
    load_image();
    step = 8'($urandom_range(255, 1));
    fade_enable = 1'b1; fade_step = step; vblank = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (sweep_active === 1'b1) break;
    end
    ov_cnt = 0; draw_early = 0; done_cnt = 0; cpu_lat = 0; cpu_t0 = 0;
    for (int i = 1; i <= 4 * N + 60; i++) begin
      tick();
      if (overrun === 1'b1) ov_cnt++;
      if (draw_ack === 1'b1) draw_early++;
      if (cpu_ack === 1'b1 && cpu_lat == 0) begin
        cpu_lat = i - cpu_t0;
        cpu_req = 1'b0;
      end
      if (sweep_done === 1'b1) begin done_cnt++; break; end
      if (i == 3) vblank = 1'b0;
      if (i == 40) vblank = 1'b1;
      if (i == 60) begin
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = '0; cpu_wdata = 8'hC3;
        draw_req = 1'b1; draw_addr = 10'h005; draw_data = 8'h99;
        cpu_t0 = i;
      end
    end
    cpu_req = 1'b0;
    check("sweepB_done_count", done_cnt, 1);
    check("sweepB_overrun_count", ov_cnt, 1);
    check("sweepB_draw_stalled", draw_early, 0);
    check("sweepB_cpu_within4", (cpu_lat >= 1 && cpu_lat <= 4) ? 1 : 0, 1);
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (draw_ack === 1'b1) begin lat = i; break; end
    end
    draw_req = 1'b0; vblank = 1'b0;
    check("sweepB_draw_after_done", lat, 1);
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sweep_done === 1'b1) done_cnt++;
    end
    check("sweepB_no_extra_done", done_cnt, 0);
    for (int i = 0; i < N; i++) exp_mem[i] = decay(img[i], step);
    exp_mem[0] = 8'hC3;
    exp_mem[10'h005] = 8'h99;
    mem_compare("sweepB_mem");

    // Random CPU traffic against the array model
    for (int k = 0; k < 24; k++) begin
      wr = 1'($urandom_range(1, 0));
      a  = AW'($urandom_range(N - 1, 0));
      d  = 8'($urandom);
      cpu_op(wr, a, d, lat, rd);
      if (wr) begin
        exp_mem[a] = d;
        check($sformatf("rnd%0d_wr_latency", k), lat, 1);
      end else begin
        check($sformatf("rnd%0d_rd_latency", k), lat, 4);
        check($sformatf("rnd%0d_rdata", k), rd, exp_mem[a]);
      end
    end
    mem_compare("random_mem");

    // Reset during SW_RD1 of pixel 3
    fade_enable = 1'b1; fade_step = 8'h01; vblank = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (sweep_active === 1'b1) break;
    end
    repeat (13) tick();
    #2 reset = 1'b1;
    vblank = 1'b0;
    #1;
    check("rstmid_fb_wr", fb_wr, 0);
    check("rstmid_sweep_active", sweep_active, 0);
    check("rstmid_acks", {draw_ack, cpu_ack}, 0);
    check("rstmid_fb_addr", fb_addr, 0);
    tick();
    tick();
    reset = 1'b0;
    done_cnt = 0; found = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (sweep_done === 1'b1) done_cnt++;
      if (sweep_active === 1'b1) found++;
    end
    check("rstmid_no_done", done_cnt, 0);
    check("rstmid_no_active", found, 0);
    vblank = 1'b1;
    found = 0; a = '1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (fb_wr === 1'b1) begin found = 1; a = fb_addr; break; end
    end
    check("fresh_sweep_write_seen", found, 1);
    check("fresh_sweep_first_addr", a, 0);
    found = 0;
    for (int i = 1; i <= 4 * N + 20; i++) begin
      tick();
      if (sweep_done === 1'b1) begin found = 1; break; end
    end
    vblank = 1'b0;
    check("fresh_sweep_done", found, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vector_fb_scheduler.md
Name: vector_fb_scheduler

Overview:
- Owns the single read/write port (port B) of the 256x256x8 vector framebuffer.
- Shares that port between three users: the line-draw engine (pixel writes), CPU debug/readback accesses, and an internal phosphor-fade sweeper.
- The sweeper starts on each vblank rising edge and applies a saturating decay to every framebuffer byte.
- Sits between the vector line renderer and the framebuffer dpram (address-registered, 2-cycle read latency).

Parameters:
FB_ADDR_WIDTH, 16, framebuffer address width; sweep covers 0 .. 2^FB_ADDR_WIDTH-1.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
vblank  in  1  vertical blank level; rising edge triggers a sweep
fade_enable  in  1  sweep permitted when high
fade_step  in  8  decay amount, latched at sweep start
draw_req  in  1  draw write request, held until draw_ack
draw_addr  in  FB_ADDR_WIDTH  pixel address {y,x}
draw_data  in  8  pixel value
draw_ack  out  1  one-cycle grant pulse for draw
cpu_req  in  1  CPU request, held until cpu_ack
cpu_wr  in  1  1 = write, 0 = read
cpu_addr  in  FB_ADDR_WIDTH  CPU address
cpu_wdata  in  8  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  8  read data, valid while cpu_ack=1, held afterwards
fb_addr  out  FB_ADDR_WIDTH  framebuffer port address (registered)
fb_wr  out  1  framebuffer write enable (registered, one-cycle pulses)
fb_wdata  out  8  framebuffer write data (registered)
fb_rdata  in  8  framebuffer read data; valid 2 cycles after fb_addr is presented
sweep_active  out  1  high from sweep start until the last write completes
sweep_done  out  1  one-cycle pulse after the last sweep write
overrun  out  1  one-cycle pulse: vblank rose while a sweep was still active

Behaviour:
- Reset (asynchronous, immediate): state IDLE; all outputs 0, including fb_addr, cpu_rdata and fb_wr; pending-sweep flag cleared.
- vblank edge detection:
  - vblank_last is registered. A rise with fade_enable=1, fade_step!=0 and sweep not active sets sweep_pending and latches fade_step.
  - A rise while sweep_active does not restart or queue a sweep and pulses overrun.
- Decision point: every cycle in IDLE. Priority is cpu > sweep > draw. Draw is ineligible while sweep_pending or sweep_active.
- Ack-cycle exclusion: no requester is granted in the cycle its own ack is high. This prevents a duplicate grant from a request not yet dropped.
- States: IDLE, CPU_RD0, CPU_RD1, CPU_RD2, SW_RD0, SW_RD1, SW_RD2, SW_WR.
- Draw grant (from IDLE):
  - At the edge: fb_addr=draw_addr, fb_wdata=draw_data, fb_wr=1, draw_ack=1. Stay in IDLE.
  - Peak rate is 1 pixel per 2 cycles.
- CPU write (from IDLE):
  - Same as draw: fb_wr and cpu_ack pulse together, one cycle after cpu_req is sampled.
- CPU read:
  - IDLE -> CPU_RD0 with fb_addr=cpu_addr, fb_wr=0.
  - CPU_RD0 -> CPU_RD1 -> CPU_RD2. In CPU_RD2, fb_rdata is captured into cpu_rdata and cpu_ack pulses at that edge.
  - Then return to IDLE. cpu_ack is high 4 cycles after the request is sampled.
- Sweep:
  - On first grant: sweep_pending clears, sweep_active sets, sweep address counter = 0.
  - Per pixel: SW_RD0 presents fb_addr=counter. SW_RD1 waits. SW_RD2 captures fb_rdata. SW_WR writes fb_wdata=sat_sub(data, step) to the same address with fb_wr=1.
  - sat_sub(d,s) = d>s ? d-s : 0 (8-bit, no wrap).
  - After SW_WR: if counter = all-ones, clear sweep_active, pulse sweep_done, go to IDLE. Otherwise increment counter and go to IDLE, which re-arbitrates so the CPU can interleave between pixels.
  - 4 cycles per pixel without CPU traffic.
- A pixel's read-modify-write is atomic: a CPU access is never inserted between SW_RD0 and SW_WR.
- Draw requests stall (no ack) for the whole sweep; the draw engine simply waits.
- fade_enable dropping mid-sweep does not abort the sweep. fade_step changes mid-sweep are ignored.
- A CPU write to the address currently inside a sweep RMW lands after SW_WR, so the CPU value wins.
- Reset mid-sweep or mid-read: abandons the operation; no ack or done is emitted.

Test Plan:
- Reset released, draw_req with addr=16'h1234, data=8'hFF -> one cycle later fb_addr=16'h1234, fb_wr=1, fb_wdata=8'hFF, draw_ack=1; if req is held, the next grant comes 2 cycles later.
- Preload fb[16'h0042]=8'h5A; CPU read of 16'h0042 -> cpu_ack 4 cycles after request, cpu_rdata=8'h5A.
- fade_step=8'h10, fb[0]=8'h25, fb[1]=8'h08, vblank rises -> fb[0]=8'h15, fb[1]=8'h00, sweep_done pulses once after 262144 sweep cycles, sweep_active low afterwards.
- draw_req and cpu_req asserted together during a sweep -> CPU serviced between pixels within 4 cycles; draw_ack withheld until after sweep_done.
- Second vblank rise while sweep_active -> overrun pulses for 1 cycle; sweep continues to completion with exactly one sweep_done.
- reset asserted during SW_RD1 -> fb_wr, sweep_active, draw_ack and cpu_ack read 0 immediately; no sweep_done follows; next vblank starts a fresh sweep at address 0.
